// File: rtl/dsn_pkg.sv
// Shared definitions for the DSN presynaptic drive path and the neuron side.
// Holds io_vpre encoding constants, the driver FSM states and sign-magnitude helpers.
package dsn_pkg;

    localparam int VPRE_W        = 9;
    localparam int VPRE_SIGN_BIT = 8;
    localparam int VPRE_MAG_MAX  = 255;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // Negative zero maps to plain zero because -0 == 0 in two's complement.
    function automatic logic signed [VPRE_W-1:0] sm_to_tc(input logic [VPRE_W-1:0] sm);
        logic signed [VPRE_W-1:0] mag;
        mag = $signed({1'b0, sm[VPRE_SIGN_BIT-1:0]});
        return sm[VPRE_SIGN_BIT] ? -mag : mag;
    endfunction

    function automatic logic [VPRE_W-1:0] tc_to_sm(input logic signed [31:0] value);
        logic [31:0] mag;
        logic        neg;
        neg = (value < 0);
        mag = neg ? 32'(-value) : 32'(value);
        if (mag > VPRE_MAG_MAX) begin
            mag = VPRE_MAG_MAX;
        end
        return {neg, mag[VPRE_SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/dsn_weight_rf.sv
// Per-synapse weight register file: one write port and one registered read port.
// A same-cycle write and read of one address returns the old weight.
module dsn_weight_rf
    import dsn_pkg::*;
#(
    parameter int N_SYN = 16,
    parameter int AW    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [VPRE_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [VPRE_W-1:0] rd_data
);

    logic [VPRE_W-1:0] mem [N_SYN];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_SYN; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            // Addresses beyond the populated range read as a zero weight.
            rd_data <= (int'(rd_addr) < N_SYN) ? mem[rd_addr] : '0;
            if (wr_en && (int'(wr_addr) < N_SYN)) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/dsn_synapse_driver.sv
// Presynaptic drive generator: accumulates spike weights per timestep, emits io_vpre on io_tick.
// Optional macro DSN_SYN_EVCOUNT_EN builds the per-timestep accepted-event counter (io_evcount).
//
// Handshake: an event transfers on a rising edge where io_in_valid && io_in_ready; io_in_ready
// is high only in ACCUM outside reset and does not depend on io_in_valid.
module dsn_synapse_driver
    import dsn_pkg::*;
#(
    parameter int N_SYN = 16,
    parameter int AW    = 4,
    parameter int ACC_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [AW-1:0]     io_in_addr,
    input  logic              io_tick,
    input  logic              io_wr_en,
    input  logic [AW-1:0]     io_wr_addr,
    input  logic [VPRE_W-1:0] io_wr_data,
    output logic [VPRE_W-1:0] io_vpre,
    output logic              io_vpre_valid,
    output logic              io_overrun,
    output logic [7:0]        io_evcount,
    output state_t            io_state
);

    localparam logic signed [ACC_W:0] ACC_MAX = (ACC_W+1)'((2 ** (ACC_W-1)) - 1);
    localparam logic signed [ACC_W:0] ACC_MIN = -ACC_MAX;

    state_t                   state;
    logic                     drain_cnt;
    logic                     accept;
    logic                     emit_now;
    logic                     s1_valid;
    logic [VPRE_W-1:0]        rd_weight;
    logic signed [VPRE_W-1:0] weight_tc;
    logic signed [ACC_W-1:0]  addend;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    sum;
    logic signed [ACC_W-1:0]  sat_sum;

    assign io_in_ready = reset && (state == ACCUM);
    assign accept      = io_in_valid && io_in_ready;
    assign emit_now    = (state == DRAIN) && drain_cnt;
    assign io_state    = state;

    // Stage 1: registered weight lookup for the accepted event.
    dsn_weight_rf #(
        .N_SYN (N_SYN),
        .AW    (AW)
    ) u_weight_rf (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (io_wr_en),
        .wr_addr (io_wr_addr),
        .wr_data (io_wr_data),
        .rd_addr (io_in_addr),
        .rd_data (rd_weight)
    );

    // Stage 2: convert and add with symmetric saturation.
    always_comb begin
        weight_tc = sm_to_tc(rd_weight);
        addend    = {{(ACC_W-VPRE_W){weight_tc[VPRE_W-1]}}, weight_tc};
        sum       = $signed({acc[ACC_W-1], acc}) + $signed({addend[ACC_W-1], addend});
        sat_sum   = sum[ACC_W-1:0];
        if (sum > ACC_MAX) begin
            sat_sum = ACC_MAX[ACC_W-1:0];
        end else if (sum < ACC_MIN) begin
            sat_sum = ACC_MIN[ACC_W-1:0];
        end
    end

    // io_vpre/io_vpre_valid are registered on the edge into EMIT, so the pulse is visible
    // during the EMIT cycle, three cycles after the tick cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ACCUM;
            drain_cnt     <= 1'b0;
            s1_valid      <= 1'b0;
            acc           <= '0;
            io_vpre       <= '0;
            io_vpre_valid <= 1'b0;
            io_overrun    <= 1'b0;
        end else begin
            s1_valid      <= accept;
            io_vpre_valid <= 1'b0;
            io_overrun    <= io_tick && (state != ACCUM);
            if (s1_valid) begin
                acc <= sat_sum;
            end
            case (state)
                ACCUM: begin
                    if (io_tick) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (emit_now) begin
                        state         <= EMIT;
                        io_vpre       <= tc_to_sm({{(32-ACC_W){acc[ACC_W-1]}}, acc});
                        io_vpre_valid <= 1'b1;
                        acc           <= '0;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                EMIT: begin
                    state <= ACCUM;
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

`ifdef DSN_SYN_EVCOUNT_EN
    logic [7:0] ev_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            ev_cnt     <= '0;
            io_evcount <= '0;
        end else if (emit_now) begin
            io_evcount <= ev_cnt;
            ev_cnt     <= '0;
        end else if (accept && (ev_cnt != 8'hFF)) begin
            ev_cnt <= ev_cnt + 8'd1;
        end
    end
`else
    assign io_evcount = '0;
`endif

endmodule

// File: tb/tb_dsn_synapse_driver.sv
// Self-checking bench for dsn_synapse_driver: directed scenarios plus randomized timesteps
// checked against a per-event arithmetic model of the weight sum.
module tb_dsn_synapse_driver;
    import dsn_pkg::*;

    localparam int N_SYN   = 16;
    localparam int AW      = 4;
    localparam int ACC_W   = 12;
    localparam int ACC_LIM = 2047;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          io_in_valid = 1'b0;
    logic          io_in_ready;
    logic [AW-1:0] io_in_addr = '0;
    logic          io_tick = 1'b0;
    logic          io_wr_en = 1'b0;
    logic [AW-1:0] io_wr_addr = '0;
    logic [8:0]    io_wr_data = '0;
    logic [8:0]    io_vpre;
    logic          io_vpre_valid;
    logic          io_overrun;
    logic [7:0]    io_evcount;
    state_t        io_state;

    int         cmp_count = 0;
    int         fail_count = 0;
    logic [8:0] w_m [N_SYN];
    int         acc_m = 0;
    int         ev_m = 0;
    logic [8:0] exp_q [$];

    dsn_synapse_driver #(.N_SYN(N_SYN), .AW(AW), .ACC_W(ACC_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_in_addr    (io_in_addr),
        .io_tick       (io_tick),
        .io_wr_en      (io_wr_en),
        .io_wr_addr    (io_wr_addr),
        .io_wr_data    (io_wr_data),
        .io_vpre       (io_vpre),
        .io_vpre_valid (io_vpre_valid),
        .io_overrun    (io_overrun),
        .io_evcount    (io_evcount),
        .io_state      (io_state)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    function automatic int sm_val(input logic [8:0] w);
        return w[8] ? -int'(w[7:0]) : int'(w[7:0]);
    endfunction

    function automatic int acc_add(input int a, input int b);
        int s;
        s = a + b;
        if (s > ACC_LIM) s = ACC_LIM;
        if (s < -ACC_LIM) s = -ACC_LIM;
        return s;
    endfunction

    function automatic logic [8:0] to_word(input int a);
        int m;
        m = (a < 0) ? -a : a;
        if (m > 255) m = 255;
        return {(a < 0), m[7:0]};
    endfunction

    function automatic logic [7:0] exp_evc(input int n);
`ifdef DSN_SYN_EVCOUNT_EN
        int c;
        c = (n > 255) ? 255 : n;
        return c[7:0];
`else
        return (n < 0) ? 8'd1 : 8'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_w(input int a, input logic [8:0] d);
        io_wr_en   = 1'b1;
        io_wr_addr = AW'(a);
        io_wr_data = d;
        step();
        io_wr_en = 1'b0;
        w_m[a] = d;
    endtask

    // Contribution uses the model weight before any write driven in the same cycle.
    task automatic send_event(input int a);
        cmp_count++;
        if (io_in_ready !== 1'b1) begin
            fail_count++;
            $display("FAIL ready_in_accum: got %b want 1", io_in_ready);
        end
        io_in_valid = 1'b1;
        io_in_addr  = AW'(a);
        step();
        io_in_valid = 1'b0;
        acc_m = acc_add(acc_m, sm_val(w_m[a]));
        ev_m++;
    endtask

    task automatic tick_and_check(input string name);
        int         n;
        logic [8:0] exp_v;
        logic [7:0] exp_e;
        exp_q.push_back(to_word(acc_m));
        exp_e = exp_evc(ev_m);
        io_tick = 1'b1;
        step();
        io_tick = 1'b0;
        n = 1;
        while (io_vpre_valid !== 1'b1 && n < 12) begin
            cmp_count++;
            if (io_in_ready !== 1'b0) begin
                fail_count++;
                $display("FAIL %s ready_in_drain: got %b want 0 (cycle %0d)", name, io_in_ready, n);
            end
            step();
            n++;
        end
        exp_v = exp_q.pop_front();
        cmp_count++;
        if (n !== 3) begin
            fail_count++;
            $display("FAIL %s latency: got %0d want 3", name, n);
        end
        cmp_count++;
        if (io_vpre !== exp_v) begin
            fail_count++;
            $display("FAIL %s vpre: got %h want %h", name, io_vpre, exp_v);
        end
        cmp_count++;
        if (io_evcount !== exp_e) begin
            fail_count++;
            $display("FAIL %s evcount: got %0d want %0d", name, io_evcount, exp_e);
        end
        cmp_count++;
        if (io_in_ready !== 1'b0 || io_overrun !== 1'b0) begin
            fail_count++;
            $display("FAIL %s emit_ready_overrun: got %b%b want 00", name, io_in_ready, io_overrun);
        end
        step();
        cmp_count++;
        if (io_vpre_valid !== 1'b0 || io_in_ready !== 1'b1 || io_vpre !== exp_v) begin
            fail_count++;
            $display("FAIL %s after_emit: got valid=%b ready=%b vpre=%h want 0 1 %h",
                     name, io_vpre_valid, io_in_ready, io_vpre, exp_v);
        end
        acc_m = 0;
        ev_m  = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N_SYN; i++) w_m[i] = '0;
        reset = 1'b0;
        repeat (3) step();
        cmp_count++;
        if (io_vpre !== 9'h000 || io_vpre_valid !== 1'b0 || io_overrun !== 1'b0 ||
            io_evcount !== 8'h00 || io_in_ready !== 1'b0 || io_state !== ACCUM) begin
            fail_count++;
            $display("FAIL reset_outputs: got vpre=%h v=%b o=%b ev=%0d rdy=%b st=%0d want all 0, ACCUM",
                     io_vpre, io_vpre_valid, io_overrun, io_evcount, io_in_ready, io_state);
        end
        reset = 1'b1;
        step();
        cmp_count++;
        if (io_in_ready !== 1'b1) begin
            fail_count++;
            $display("FAIL reset_release_ready: got %b want 1", io_in_ready);
        end
    endtask

    task automatic test_basic();
        write_w(3, 9'h005);
        for (int i = 0; i < 4; i++) send_event(3);
        tick_and_check("basic_x4");
    endtask

    task automatic test_signed();
        write_w(0, 9'h00A);
        write_w(1, 9'h11E);
        send_event(0);
        send_event(1);
        tick_and_check("signed_sum");
        tick_and_check("empty_step");
    endtask

    task automatic test_mag_sat();
        write_w(2, 9'h0C8);
        for (int i = 0; i < 3; i++) send_event(2);
        tick_and_check("mag_sat");
    endtask

    // Climbing past the accumulator limit and coming back down exposes wrap vs clamp.
    task automatic test_acc_saturation();
        write_w(6, 9'h0C8);
        write_w(7, 9'h1FF);
        for (int i = 0; i < 12; i++) send_event(6);
        for (int i = 0; i < 8; i++) send_event(7);
        tick_and_check("acc_sat");
    endtask

    task automatic test_tick_overlap();
        int         nv;
        logic [8:0] exp_v;
        logic [7:0] exp_e;
        write_w(3, 9'h003);
        send_event(3);
        io_in_valid = 1'b1;
        io_in_addr  = AW'(3);
        io_tick     = 1'b1;
        step();
        io_in_valid = 1'b0;
        acc_m = acc_add(acc_m, sm_val(w_m[3]));
        ev_m++;
        exp_v = to_word(acc_m);
        exp_e = exp_evc(ev_m);
        step();
        io_tick = 1'b0;
        cmp_count++;
        if (io_overrun !== 1'b1) begin
            fail_count++;
            $display("FAIL overrun_pulse: got %b want 1", io_overrun);
        end
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (io_vpre_valid === 1'b1) begin
                nv++;
                cmp_count++;
                if (io_vpre !== exp_v || io_evcount !== exp_e) begin
                    fail_count++;
                    $display("FAIL overlap_word: got %h/%0d want %h/%0d", io_vpre, io_evcount, exp_v, exp_e);
                end
            end
        end
        cmp_count++;
        if (nv !== 1) begin
            fail_count++;
            $display("FAIL overlap_valid_count: got %0d want 1", nv);
        end
        acc_m = 0;
        ev_m  = 0;
    endtask

    task automatic test_write_collision();
        write_w(5, 9'h001);
        io_wr_en   = 1'b1;
        io_wr_addr = AW'(5);
        io_wr_data = 9'h007;
        send_event(5);
        io_wr_en = 1'b0;
        w_m[5] = 9'h007;
        send_event(5);
        tick_and_check("write_collision");
    endtask

    task automatic test_random();
        for (int ts = 0; ts < 8; ts++) begin
            int ne;
            for (int k = 0; k < 4; k++) write_w($urandom_range(0, N_SYN-1), 9'($urandom_range(0, 511)));
            ne = $urandom_range(0, 24);
            for (int e = 0; e < ne; e++) begin
                int         a;
                int         wa;
                logic [8:0] wd;
                a = $urandom_range(0, N_SYN-1);
                if ($urandom_range(0, 3) == 0) begin
                    wa = $urandom_range(0, N_SYN-1);
                    wd = 9'($urandom_range(0, 511));
                    io_wr_en   = 1'b1;
                    io_wr_addr = AW'(wa);
                    io_wr_data = wd;
                    send_event(a);
                    io_wr_en = 1'b0;
                    w_m[wa] = wd;
                end else begin
                    send_event(a);
                end
                if ($urandom_range(0, 2) == 0) step();
            end
            tick_and_check("random");
        end
    endtask

    task automatic test_reset_mid();
        int nv;
        write_w(5, 9'h0FF);
        send_event(5);
        send_event(5);
        io_tick = 1'b1;
        step();
        io_tick = 1'b0;
        reset = 1'b0;
        step();
        step();
        cmp_count++;
        if (io_vpre !== 9'h000 || io_vpre_valid !== 1'b0 || io_overrun !== 1'b0 ||
            io_evcount !== 8'h00 || io_in_ready !== 1'b0) begin
            fail_count++;
            $display("FAIL reset_mid_outputs: got vpre=%h v=%b o=%b ev=%0d rdy=%b want all 0",
                     io_vpre, io_vpre_valid, io_overrun, io_evcount, io_in_ready);
        end
        reset = 1'b1;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (io_vpre_valid === 1'b1) nv++;
        end
        cmp_count++;
        if (nv !== 0) begin
            fail_count++;
            $display("FAIL reset_mid_no_emit: got %0d valid pulses want 0", nv);
        end
        for (int i = 0; i < N_SYN; i++) w_m[i] = '0;
        acc_m = 0;
        ev_m  = 0;
        send_event(5);
        tick_and_check("reset_mid_cleared");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_mag_sat();
        test_acc_saturation();
        test_tick_overlap();
        test_write_collision();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
